// File: rtl/mux_pkg.sv
// Shared constants for the registered N:1 mux: selection modes and index-width helper.
// No logic; imported by mux_rr_reg and rr_arbiter.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Index width for n items, never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester after ptr, wrapping modulo N.
// Zero latency; no state, no backpressure of its own.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt_onehot,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [2*N-1:0] w_req2;
    logic [2*N-1:0] w_mask;
    logic [2*N-1:0] w_masked;

    // Doubling the request vector turns the wrap-around search into a plain
    // lowest-set-bit search over the window ptr+1 .. ptr+N.
    always_comb begin
        w_req2 = {req, req};
        w_mask = '0;
        for (int i = 0; i < 2 * N; i++) begin
            w_mask[i] = (i > int'(ptr)) && (i <= int'(ptr) + N);
        end
        w_masked = w_req2 & w_mask;
    end

    always_comb begin
        gnt_idx    = '0;
        gnt_any    = |w_masked;
        gnt_onehot = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                gnt_idx = SELW'(i % N);
            end
        end
        for (int k = 0; k < N; k++) begin
            gnt_onehot[k] = gnt_any && (gnt_idx == SELW'(k));
        end
    end

endmodule

// File: rtl/mux_rr_reg.sv
// N:1 valid/ready mux, manual or round-robin select, single-entry output register.
// Latency 1 cycle; full throughput; in_ready follows accept = !out_valid || out_ready.
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    logic [N-1:0]     w_rr_onehot;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_rr_any;
    logic             w_man_any;
    logic [SELW-1:0]  w_gnt_idx;
    logic             w_gnt_any;
    logic             w_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    rr_arbiter #(.N(N)) u_arb (
        .req        (in_valid),
        .ptr        (r_ptr),
        .gnt_onehot (w_rr_onehot),
        .gnt_idx    (w_rr_idx),
        .gnt_any    (w_rr_any)
    );

    // Compare against each legal index so an out-of-range sel never grants.
    always_comb begin
        w_man_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k) && in_valid[k]) begin
                w_man_any = 1'b1;
            end
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            w_gnt_idx = w_rr_idx;
            w_gnt_any = w_rr_any && (|w_rr_onehot);
        end else begin
            w_gnt_idx = sel;
            w_gnt_any = w_man_any;
        end
    end

    assign w_accept = !r_out_valid || out_ready;
    assign w_xfer   = w_gnt_any && w_accept;

    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt_idx == SELW'(k)) begin
                in_ready[k] = rst_n && w_xfer;
                w_sel_data  = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SELW'(N - 1);
        end else if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_gnt_idx;
            r_out_valid <= 1'b1;
            r_ptr       <= w_gnt_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed scoreboard bench for mux_rr_reg (N=4, WIDTH=8).
module tb_mux_rr_reg;

    typedef struct {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    int   checks;
    int   errors;
    exp_t q[$];
    logic [7:0] tbl [4];

    mux_rr_reg #(.N(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.chan = 2'(ch);
        e.data = tbl[ch];
        q.push_back(e);
    endtask

    // Monitor: every completed output handshake must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got chan %0d data %0h, none expected", out_chan, out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_chan", 32'(out_chan), 32'(e.chan));
                    chk("out_data", 32'(out_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        int rr_seq [4];
        checks   = 0;
        errors   = 0;
        tbl[0]   = 8'hA0;
        tbl[1]   = 8'hB1;
        tbl[2]   = 8'hC2;
        tbl[3]   = 8'hD3;
        in_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        rst_n    = 1'b1;
        mode     = 1'b1;
        sel      = 2'd0;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data",  32'(out_data), 0);
        chk("reset_out_chan",  32'(out_chan), 0);
        in_valid = 4'b1111;
        #1;
        chk("reset_in_ready", 32'(in_ready), 0);
        in_valid = 4'b0000;
        step();
        step();
        rst_n = 1'b1;

        // Round-robin over all channels: 0,1,2,3,0.
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #0;
            chk("rr_all_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
            push(i % 4);
            step();
        end
        in_valid = 4'b0000;
        step();
        chk("rr_all_drained", 32'(out_valid), 0);

        // Sparse round-robin: 1,3,1,3.
        rr_seq   = '{1, 3, 1, 3};
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #0;
            chk("rr_sparse_in_ready", 32'(in_ready), 32'(1 << rr_seq[i]));
            push(rr_seq[i]);
            step();
        end
        in_valid = 4'b0000;
        step();

        // Backpressure with B1 held in the output register.
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        push(1);
        step();
        in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #0;
            chk("stall_in_ready",  32'(in_ready), 0);
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_out_data",  32'(out_data), 32'h00B1);
            chk("stall_out_chan",  32'(out_chan), 1);
            step();
        end
        out_ready = 1'b1;
        #0;
        chk("release_in_ready", 32'(in_ready), 32'b0100);
        push(2);
        step();
        in_valid = 4'b0000;
        step();

        // Manual select of channel 2, then withdraw its valid.
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        #0;
        chk("manual_in_ready", 32'(in_ready), 32'b0100);
        push(2);
        step();
        chk("manual_out_valid", 32'(out_valid), 1);
        in_valid = 4'b0000;
        #0;
        chk("manual_none_in_ready", 32'(in_ready), 0);
        step();
        chk("manual_drained", 32'(out_valid), 0);

        // Selected channel not valid: no grant even though others are.
        in_valid = 4'b0100;
        push(2);
        step();
        in_valid = 4'b1011;
        #0;
        chk("manual_invalid_sel_in_ready", 32'(in_ready), 0);
        step();
        chk("manual_invalid_sel_drained", 32'(out_valid), 0);

        // Switch to round-robin with ptr at 2: grants 3 then 0.
        mode = 1'b1;
        #0;
        chk("switch_rr_in_ready_3", 32'(in_ready), 32'b1000);
        push(3);
        step();
        chk("switch_rr_in_ready_0", 32'(in_ready), 32'b0001);
        push(0);
        step();
        in_valid = 4'b0000;
        step();

        // Asynchronous reset while the output register holds data.
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        step();
        chk("pre_reset_out_valid", 32'(out_valid), 1);
        in_valid = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 32'(out_valid), 0);
        chk("async_reset_out_data",  32'(out_data), 0);
        chk("async_reset_out_chan",  32'(out_chan), 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        #0;
        chk("post_reset_ptr_in_ready", 32'(in_ready), 32'b0001);
        push(0);
        step();
        in_valid = 4'b0000;
        step();

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            step();
        end
        chk("scoreboard_empty", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
